timer_set_ctrl: RTL and testbench

Time-setting controller for the BCD hour/minute/second timer. Converts three push-key inputs into a set-mode state machine. It freezes the timer (CE low), edits a shadow copy of the time one field at a time with BCD wrap, and commits the result through a one-cycle PE load. It sits between the debounced key inputs and the timer's CE/PE/D_H/D_M/D_S pins, and feeds the display's field-select and blink.

---
 rtl/timer_pkg.sv | 37 +++
 rtl/bcd_step.sv | 40 ++++
 rtl/timer_set_ctrl.sv | 160 ++++++++++++++++
 tb/tb_timer_set_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// ============================================================================
// Module   : timer_pkg
// Brief    : Shared types and constants for the timer set-mode controller.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package timer_pkg;

  typedef enum logic [2:0] {
    RUN   = 3'd0,
    SET_H = 3'd1,
    SET_M = 3'd2,
    SET_S = 3'd3,
    LOAD  = 3'd4
  } state_e;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_HOUR = 2'd1;
  localparam logic [1:0] SEL_MIN  = 2'd2;
  localparam logic [1:0] SEL_SEC  = 2'd3;

  localparam logic [7:0] MOD_60 = 8'h59;
  localparam logic [7:0] MOD_24 = 8'h23;

  function automatic logic [1:0] sel_of(input state_e s);
    case (s)
      SET_H:   return SEL_HOUR;
      SET_M:   return SEL_MIN;
      SET_S:   return SEL_SEC;
      default: return SEL_NONE;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_step.sv
// ============================================================================
// Module   : bcd_step
// Brief    : One BCD increment/decrement with wrap at MAX; invalid input -> 00.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_step (
  input  logic [7:0] val_i,
  input  logic       up_i,
  input  logic [7:0] max_i,
  output logic [7:0] nxt_o
);

  logic [3:0] w_hi;
  logic [3:0] w_lo;
  logic       w_bad;

  assign w_hi  = val_i[7:4];
  assign w_lo  = val_i[3:0];
  assign w_bad = (w_hi > 4'd9) | (w_lo > 4'd9) | (val_i > max_i);

  always_comb begin
    nxt_o = val_i;
    if (w_bad) begin
      nxt_o = 8'h00;
    end else if (up_i) begin
      if (val_i == max_i)    nxt_o = 8'h00;
      else if (w_lo == 4'd9) nxt_o = {w_hi + 4'd1, 4'd0};
      else                   nxt_o = {w_hi, w_lo + 4'd1};
    end else begin
      if (val_i == 8'h00)    nxt_o = max_i;
      else if (w_lo == 4'd0) nxt_o = {w_hi - 4'd1, 4'd9};
      else                   nxt_o = {w_hi, w_lo - 4'd1};
    end
  end

endmodule

`default_nettype wire

// File: rtl/timer_set_ctrl.sv
// ============================================================================
// Module   : timer_set_ctrl
// Brief    : Key-driven set mode for the BCD H:M:S timer (freeze, edit, load).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module timer_set_ctrl
  import timer_pkg::*;
#(
  parameter int BLINK_DIV = 25000000,
  parameter int TIMEOUT   = 250000000,
  parameter int CNT_W     = 28
) (
  input  logic       CP,
  input  logic       CR,
  input  logic       KEY_MODE,
  input  logic       KEY_INC,
  input  logic       KEY_DEC,
  input  logic [7:0] Q_H,
  input  logic [7:0] Q_M,
  input  logic [7:0] Q_S,
  output logic       CE,
  output logic       PE,
  output logic [7:0] D_H,
  output logic [7:0] D_M,
  output logic [7:0] D_S,
  output logic [1:0] SEL,
  output logic       BLINK,
  output logic       SETTING
);

  localparam logic [CNT_W-1:0] c_to_last    = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_blink_last = CNT_W'(BLINK_DIV - 1);

  state_e           state_q, state_d;
  logic             mode_prev_q, inc_prev_q, dec_prev_q;
  logic [7:0]       sh_h_q, sh_m_q, sh_s_q;
  logic [7:0]       sh_h_d, sh_m_d, sh_s_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic [CNT_W-1:0] blk_cnt_q, blk_cnt_d;
  logic             blink_q, blink_d;
  logic             ce_q, pe_q, setting_q;
  logic [1:0]       sel_q;

  logic       w_mode_ev, w_inc_raw, w_dec_raw, w_any_ev;
  logic       w_inc_ev, w_dec_ev, w_in_set, w_edit;
  logic [7:0] w_h_nxt, w_m_nxt, w_s_nxt;

  assign w_mode_ev = KEY_MODE & ~mode_prev_q;
  assign w_inc_raw = KEY_INC & ~inc_prev_q;
  assign w_dec_raw = KEY_DEC & ~dec_prev_q;
  assign w_any_ev  = w_mode_ev | w_inc_raw | w_dec_raw;
  // MODE wins the cycle; simultaneous INC+DEC cancel each other.
  assign w_inc_ev  = w_inc_raw & ~w_dec_raw & ~w_mode_ev;
  assign w_dec_ev  = w_dec_raw & ~w_inc_raw & ~w_mode_ev;
  assign w_in_set  = (state_q == SET_H) | (state_q == SET_M) | (state_q == SET_S);
  assign w_edit    = w_in_set & (w_inc_ev | w_dec_ev);

  bcd_step u_step_h (.val_i(sh_h_q), .up_i(w_inc_ev), .max_i(MOD_24), .nxt_o(w_h_nxt));
  bcd_step u_step_m (.val_i(sh_m_q), .up_i(w_inc_ev), .max_i(MOD_60), .nxt_o(w_m_nxt));
  bcd_step u_step_s (.val_i(sh_s_q), .up_i(w_inc_ev), .max_i(MOD_60), .nxt_o(w_s_nxt));

  always_comb begin
    state_d  = state_q;
    sh_h_d   = sh_h_q;
    sh_m_d   = sh_m_q;
    sh_s_d   = sh_s_q;
    to_cnt_d = '0;
    case (state_q)
      RUN: begin
        if (w_mode_ev) begin
          state_d = SET_H;
          sh_h_d  = Q_H;
          sh_m_d  = Q_M;
          sh_s_d  = Q_S;
        end
      end
      SET_H, SET_M, SET_S: begin
        if (w_any_ev)                   to_cnt_d = '0;
        else if (to_cnt_q == c_to_last) state_d  = RUN;
        else                            to_cnt_d = to_cnt_q + CNT_W'(1);
        if (w_mode_ev) begin
          case (state_q)
            SET_H:   state_d = SET_M;
            SET_M:   state_d = SET_S;
            default: state_d = LOAD;
          endcase
        end else if (w_edit) begin
          case (state_q)
            SET_H:   sh_h_d = w_h_nxt;
            SET_M:   sh_m_d = w_m_nxt;
            default: sh_s_d = w_s_nxt;
          endcase
        end
      end
      LOAD:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Blink phase restarts whenever the view changes so the new field is shown first.
  always_comb begin
    blk_cnt_d = blk_cnt_q + CNT_W'(1);
    blink_d   = blink_q;
    if ((state_d != state_q) || w_edit || (sel_of(state_d) == SEL_NONE)) begin
      blk_cnt_d = '0;
      blink_d   = 1'b0;
    end else if (blk_cnt_q == c_blink_last) begin
      blk_cnt_d = '0;
      blink_d   = ~blink_q;
    end
  end

  always_ff @(posedge CP) begin
    if (CR) begin
      state_q     <= RUN;
      mode_prev_q <= 1'b0;
      inc_prev_q  <= 1'b0;
      dec_prev_q  <= 1'b0;
      sh_h_q      <= 8'h00;
      sh_m_q      <= 8'h00;
      sh_s_q      <= 8'h00;
      to_cnt_q    <= '0;
      blk_cnt_q   <= '0;
      blink_q     <= 1'b0;
      ce_q        <= 1'b1;
      pe_q        <= 1'b0;
      sel_q       <= SEL_NONE;
      setting_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_prev_q <= KEY_MODE;
      inc_prev_q  <= KEY_INC;
      dec_prev_q  <= KEY_DEC;
      sh_h_q      <= sh_h_d;
      sh_m_q      <= sh_m_d;
      sh_s_q      <= sh_s_d;
      to_cnt_q    <= to_cnt_d;
      blk_cnt_q   <= blk_cnt_d;
      blink_q     <= blink_d;
      ce_q        <= (state_d == RUN);
      pe_q        <= (state_d == LOAD);
      sel_q       <= sel_of(state_d);
      setting_q   <= (sel_of(state_d) != SEL_NONE);
    end
  end

  assign CE      = ce_q;
  assign PE      = pe_q;
  assign D_H     = sh_h_q;
  assign D_M     = sh_m_q;
  assign D_S     = sh_s_q;
  assign SEL     = sel_q;
  assign BLINK   = blink_q;
  assign SETTING = setting_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_set_ctrl.sv
// ============================================================================
// Module   : tb_timer_set_ctrl
// Brief    : Directed + random bench for timer_set_ctrl with a numeric model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_timer_set_ctrl;

  localparam int BLINK_DIV = 8;
  localparam int TIMEOUT   = 64;

  logic       CP = 1'b0;
  logic       CR = 1'b1;
  logic       KEY_MODE = 1'b0, KEY_INC = 1'b0, KEY_DEC = 1'b0;
  logic [7:0] Q_H = 8'h00, Q_M = 8'h00, Q_S = 8'h00;
  logic       CE, PE, BLINK, SETTING;
  logic [7:0] D_H, D_M, D_S;
  logic [1:0] SEL;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  timer_set_ctrl #(.BLINK_DIV(BLINK_DIV), .TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
    .CP(CP), .CR(CR), .KEY_MODE(KEY_MODE), .KEY_INC(KEY_INC), .KEY_DEC(KEY_DEC),
    .Q_H(Q_H), .Q_M(Q_M), .Q_S(Q_S), .CE(CE), .PE(PE),
    .D_H(D_H), .D_M(D_M), .D_S(D_S), .SEL(SEL), .BLINK(BLINK), .SETTING(SETTING)
  );

  always #5 CP = ~CP;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0=run, 1..3=editing hour/min/sec, 4=load; fields held as BCD bytes.
  int         m_mode = 0;
  logic [7:0] m_sh[3] = '{8'h00, 8'h00, 8'h00};
  int         m_idle = 0;
  int         m_since = 0;
  bit         pm = 0, pi = 0, pd = 0;

  function automatic logic [7:0] bcd_model(input logic [7:0] v, input bit up, input int maxd);
    int hi, lo, n;
    hi = int'(v[7:4]);
    lo = int'(v[3:0]);
    if (hi > 9 || lo > 9 || hi * 10 + lo > maxd) return 8'h00;
    n = hi * 10 + lo;
    n = up ? (n + 1) % (maxd + 1) : (n + maxd) % (maxd + 1);
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  always @(posedge CP) begin : mdl
    bit me, ie, de, any, up, dn;
    int f;
    if (CR) begin
      m_mode = 0; m_sh = '{8'h00, 8'h00, 8'h00}; m_idle = 0; m_since = 0;
      pm = 0; pi = 0; pd = 0;
    end else begin
      me = KEY_MODE && !pm; ie = KEY_INC && !pi; de = KEY_DEC && !pd;
      any = me || ie || de;
      up = ie && !de && !me;
      dn = de && !ie && !me;
      if (m_mode == 0) begin
        if (me) begin
          m_mode = 1; m_sh[0] = Q_H; m_sh[1] = Q_M; m_sh[2] = Q_S;
          m_idle = 0; m_since = 0;
        end
      end else if (m_mode == 4) begin
        m_mode = 0;
      end else if (me) begin
        m_mode = m_mode + 1; m_idle = 0; m_since = 0;
      end else if (up || dn) begin
        f = m_mode - 1;
        m_sh[f] = bcd_model(m_sh[f], up, (f == 0) ? 23 : 59);
        m_idle = 0; m_since = 0;
      end else if (any) begin
        m_idle = 0; m_since++;
      end else if (m_idle == TIMEOUT - 1) begin
        m_mode = 0;
      end else begin
        m_idle++; m_since++;
      end
      pm = KEY_MODE; pi = KEY_INC; pd = KEY_DEC;
    end
  end

  always @(negedge CP) begin
    if (chk_en) begin
      bit setm;
      setm = (m_mode >= 1 && m_mode <= 3);
      chk("cyc_CE", {7'd0, CE}, {7'd0, m_mode == 0});
      chk("cyc_PE", {7'd0, PE}, {7'd0, m_mode == 4});
      chk("cyc_SEL", {6'd0, SEL}, setm ? 8'(m_mode) : 8'd0);
      chk("cyc_SETTING", {7'd0, SETTING}, {7'd0, setm});
      chk("cyc_BLINK", {7'd0, BLINK}, setm ? 8'((m_since / BLINK_DIV) % 2) : 8'd0);
      chk("cyc_D_H", D_H, m_sh[0]);
      chk("cyc_D_M", D_M, m_sh[1]);
      chk("cyc_D_S", D_S, m_sh[2]);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge CP);
  endtask

  task automatic press(input bit m, input bit i, input bit d);
    KEY_MODE = m; KEY_INC = i; KEY_DEC = d;
    @(negedge CP);
    KEY_MODE = 0; KEY_INC = 0; KEY_DEC = 0;
    @(negedge CP);
  endtask

  function automatic logic [7:0] rnd_bcd(input int hi_max);
    if ($urandom_range(0, 7) == 0) return 8'($urandom);
    return {4'($urandom_range(0, hi_max)), 4'($urandom_range(0, 9))};
  endfunction

  initial begin
    cyc(2);
    CR = 0; Q_H = 8'h12;
    chk_en = 1;
    chk("rst_CE", {7'd0, CE}, 8'd1);
    chk("rst_PE", {7'd0, PE}, 8'd0);
    chk("rst_SEL", {6'd0, SEL}, 8'd0);
    chk("rst_BLINK", {7'd0, BLINK}, 8'd0);
    cyc(1);
    chk("rst_D_H", D_H, 8'h00);

    // Hours edit with wrap in both directions
    Q_H = 8'h12; Q_M = 8'h34; Q_S = 8'h56;
    press(1, 0, 0);
    chk("seth_SEL", {6'd0, SEL}, 8'd1);
    chk("seth_CE", {7'd0, CE}, 8'd0);
    chk("seth_D_H", D_H, 8'h12);
    repeat (12) press(0, 1, 0);
    chk("hinc_wrap", D_H, 8'h00);
    press(0, 0, 1);
    chk("hdec_wrap", D_H, 8'h23);

    press(1, 0, 0);
    repeat (26) press(0, 1, 0);
    chk("minc_wrap", D_M, 8'h00);
    press(1, 1, 0);
    chk("prio_SEL", {6'd0, SEL}, 8'd3);
    chk("prio_D_M", D_M, 8'h00);
    press(0, 1, 1);
    chk("incdec_D_S", D_S, 8'h56);
    press(0, 0, 1);
    chk("sdec_D_S", D_S, 8'h55);

    KEY_MODE = 1;
    @(negedge CP);
    chk("load_PE", {7'd0, PE}, 8'd1);
    chk("load_CE", {7'd0, CE}, 8'd0);
    chk("load_D", 8'(D_H == 8'h23 && D_M == 8'h00 && D_S == 8'h55), 8'd1);
    KEY_MODE = 0;
    @(negedge CP);
    chk("post_PE", {7'd0, PE}, 8'd0);
    chk("post_CE", {7'd0, CE}, 8'd1);

    // Blink phase and timeout restart
    press(1, 0, 0);
    cyc(6);
    chk("blink_lo", {7'd0, BLINK}, 8'd0);
    cyc(1);
    chk("blink_hi", {7'd0, BLINK}, 8'd1);
    cyc(31);
    press(0, 1, 0);
    chk("to_inc_D_H", D_H, 8'h13);
    cyc(62);
    chk("to_still_set", {6'd0, SEL}, 8'd1);
    cyc(1);
    chk("to_SEL", {6'd0, SEL}, 8'd0);
    chk("to_CE", {7'd0, CE}, 8'd1);

    // Held key gives a single increment, then set mode times out
    press(1, 0, 0);
    KEY_INC = 1;
    cyc(100);
    KEY_INC = 0;
    cyc(1);
    chk("held_D_H", D_H, 8'h13);
    chk("held_SEL", {6'd0, SEL}, 8'd0);

    // Reset mid-set
    press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
    chk("midset_SEL", {6'd0, SEL}, 8'd3);
    CR = 1;
    @(negedge CP);
    CR = 0;
    chk("cr_SEL", {6'd0, SEL}, 8'd0);
    chk("cr_D_S", D_S, 8'h00);
    chk("cr_CE", {7'd0, CE}, 8'd1);

    // Invalid captured seconds
    Q_S = 8'h7A;
    press(1, 0, 0); press(1, 0, 0); press(1, 0, 0);
    chk("inv_cap", D_S, 8'h7A);
    press(0, 1, 0);
    chk("inv_inc", D_S, 8'h00);
    press(1, 0, 0);
    cyc(2);

    for (int i = 0; i < 1200; i++) begin
      if (i % 200 == 100) begin
        KEY_MODE = 0; KEY_INC = 0; KEY_DEC = 0;
        press(1, 0, 0);
        cyc(70);
      end
      CR       = ($urandom_range(0, 299) == 0);
      KEY_MODE = ($urandom_range(0, 9) == 0);
      KEY_INC  = ($urandom_range(0, 3) == 0);
      KEY_DEC  = ($urandom_range(0, 3) == 0);
      Q_H = rnd_bcd(2); Q_M = rnd_bcd(5); Q_S = rnd_bcd(5);
      @(negedge CP);
    end
    CR = 0; KEY_MODE = 0; KEY_INC = 0; KEY_DEC = 0;
    cyc(3);
    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
